// File: rtl/mult_booth_seq_if.sv
// Bus between a requester and the sequential radix-4 Booth multiplier.
// Operand inputs and product outputs are grouped here; clock and reset stay plain ports.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is sampled on a rising clock edge whenever the multiplier
  // is not busy (IDLE or DONE). The operands and is_signed are captured on that
  // same edge and are ignored afterwards. While busy=1, start and the operands
  // are ignored. ready is high for exactly one cycle when result/overflow are
  // newly valid. result/overflow then hold until the next completion or a reset.
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     result;
  logic                   overflow;
  logic                   busy;
  logic                   ready;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  result, overflow, busy, ready
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output result, overflow, busy, ready
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, WIDTH/2+1 steps per product.
// The FSM state is exported on state_dbg (0 = IDLE, 1 = RUN, 2 = DONE).
module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  mult_booth_seq_if.slave       bus,
  output logic [1:0]            state_dbg
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      count;
  logic [XW-1:0]      m_reg;
  logic [XW-1:0]      q_reg;
  logic               q_m1;
  logic [AW-1:0]      acc;
  logic               signed_reg;
  logic [2*WIDTH-1:0] result_q;
  logic               overflow_q;

  logic               start_op;
  logic               last_step;
  logic [AW-1:0]      m_a;
  logic [AW-1:0]      m2_a;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_shift;
  logic [XW-1:0]      q_shift;
  logic [2*WIDTH-1:0] prod_lo;
  logic               ov_nxt;

  assign start_op  = (state != RUN) && bus.start;
  assign last_step = (count == CW'(N - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth recoding of {Q1,Q0,Q-1}; the accumulator is two bits wider than the
  // extended multiplicand so that +/-2M never wraps.
  always_comb begin
    m_a    = {{(AW - XW){m_reg[XW-1]}}, m_reg};
    m2_a   = {m_a[AW-2:0], 1'b0};
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_a;
      3'b011:         addend = m2_a;
      3'b100:         addend = -m2_a;
      3'b101, 3'b110: addend = -m_a;
      default:        addend = '0;
    endcase
    sum       = acc + addend;
    acc_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_shift   = {sum[1:0], q_reg[XW-1:2]};
    prod_lo   = {acc_shift[WIDTH-3:0], q_shift};
    if (signed_reg) begin
      ov_nxt = !((&prod_lo[2*WIDTH-1:WIDTH-1]) || (~|prod_lo[2*WIDTH-1:WIDTH-1]));
    end else begin
      ov_nxt = |prod_lo[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      acc        <= '0;
      signed_reg <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (start_op) begin
      m_reg      <= {{2{bus.multiplicand[WIDTH-1] & bus.is_signed}}, bus.multiplicand};
      q_reg      <= {{2{bus.multiplier[WIDTH-1] & bus.is_signed}}, bus.multiplier};
      q_m1       <= 1'b0;
      acc        <= '0;
      count      <= '0;
      signed_reg <= bus.is_signed;
    end else if (state == RUN) begin
      acc   <= acc_shift;
      q_reg <= q_shift;
      q_m1  <= q_reg[1];
      count <= count + CW'(1);
      if (last_step) begin
        result_q   <= prod_lo;
        overflow_q <= ov_nxt;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state == RUN);
  assign bus.ready    = (state == DONE);
  assign state_dbg    = state;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: a table of hand-computed products plus
// sequences for start-during-busy, back-to-back, async reset and an 8-bit instance.
module tb_mult_booth_seq;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] dbg32;
  logic [1:0] dbg8;

  always #5 clock = ~clock;

  mult_booth_seq_if #(.WIDTH(32)) bus32 ();
  mult_booth_seq_if #(.WIDTH(8))  bus8 ();

  mult_booth_seq #(.WIDTH(32)) dut32 (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus32),
    .state_dbg (dbg32)
  );

  mult_booth_seq #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus8),
    .state_dbg (dbg8)
  );

  typedef struct {
    logic        s;
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp_r;
    logic        exp_ov;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] exp_q[$];
  int          n_applied = 0;
  int          n_miss    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Presents an operation for one start edge, then scrambles the operands.
  task automatic launch32(input logic s, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp_r);
    @(negedge clock);
    bus32.start        = 1'b1;
    bus32.is_signed    = s;
    bus32.multiplicand = m;
    bus32.multiplier   = q;
    exp_q.push_back(exp_r);
    @(posedge clock);
    #1;
    bus32.start        = 1'b0;
    bus32.multiplicand = $urandom;
    bus32.multiplier   = $urandom;
    bus32.is_signed    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait32(input string tag, input int exp_lat, input logic exp_ov);
    int          lat;
    logic        busy_ok;
    logic [63:0] exp_r;
    busy_ok = bus32.busy;
    lat     = 0;
    while (!bus32.ready && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (!bus32.ready && !bus32.busy) busy_ok = 1'b0;
    end
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, bus32.result, exp_r);
    check({tag, " overflow"}, 64'(bus32.overflow), 64'(exp_ov));
  endtask

  task automatic run8(input logic s, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp_r, input logic exp_ov, input string tag);
    int lat;
    @(negedge clock);
    bus8.start        = 1'b1;
    bus8.is_signed    = s;
    bus8.multiplicand = m;
    bus8.multiplier   = q;
    @(posedge clock);
    #1;
    bus8.start        = 1'b0;
    bus8.multiplicand = 8'h5A;
    bus8.multiplier   = 8'hA5;
    lat = 0;
    while (!bus8.ready && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd5);
    check({tag, " result"}, 64'(bus8.result), 64'(exp_r));
    check({tag, " overflow"}, 64'(bus8.overflow), 64'(exp_ov));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0};
    vecs[9]  = '{1'b1, 32'h1234_5678, 32'h0000_0002, 64'h0000_0000_2468_ACF0, 1'b0};
    vecs[10] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0};

    bus8.start = 1'b0;  bus8.is_signed = 1'b0;
    bus8.multiplicand = '0;  bus8.multiplier = '0;

    // Reset state, with start already asserted for the first operation.
    bus32.start        = 1'b1;
    bus32.is_signed    = 1'b1;
    bus32.multiplicand = 32'h0000_0007;
    bus32.multiplier   = 32'hFFFF_FFFD;
    repeat (3) @(posedge clock);
    #1;
    check("reset result", bus32.result, 64'h0);
    check("reset overflow", 64'(bus32.overflow), 64'd0);
    check("reset busy", 64'(bus32.busy), 64'd0);
    check("reset ready", 64'(bus32.ready), 64'd0);
    check("reset state", 64'(dbg32), 64'd0);

    // First rising edge with resetn high must take the pending start.
    @(negedge clock);
    resetn = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clock);
    #1;
    bus32.start = 1'b0;
    wait32("first_start", 17, 1'b0);

    for (int i = 0; i < 12; i++) begin
      launch32(vecs[i].s, vecs[i].m, vecs[i].q, vecs[i].exp_r);
      wait32($sformatf("vec%0d", i), 17, vecs[i].exp_ov);
      if (i % 2 == 1) begin
        repeat (3) @(posedge clock);
        #1;
        check($sformatf("vec%0d idle ready", i), 64'(bus32.ready), 64'd0);
        check($sformatf("vec%0d idle state", i), 64'(dbg32), 64'd0);
        check($sformatf("vec%0d held result", i), bus32.result, vecs[i].exp_r);
      end
    end

    // Start pulse during RUN is ignored; then back-to-back start from DONE.
    repeat (2) @(posedge clock);
    launch32(1'b1, 32'd2, 32'd3, 64'd6);
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus32.start        = 1'b1;
    bus32.is_signed    = 1'b1;
    bus32.multiplicand = 32'd9;
    bus32.multiplier   = 32'd9;
    @(posedge clock);
    #1;
    bus32.start = 1'b0;
    wait32("busy_start", 11, 1'b0);
    launch32(1'b1, 32'd9, 32'd9, 64'd81);
    check("b2b ready fall", 64'(bus32.ready), 64'd0);
    wait32("b2b", 17, 1'b0);

    // Asynchronous reset in the middle of RUN.
    launch32(1'b1, 32'd9, 32'd9, 64'd81);
    repeat (6) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("async result", bus32.result, 64'h0);
    check("async overflow", 64'(bus32.overflow), 64'd0);
    check("async busy", 64'(bus32.busy), 64'd0);
    check("async ready", 64'(bus32.ready), 64'd0);
    check("async state", 64'(dbg32), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (bus32.ready || bus32.busy) stray++;
    end
    check("no stale ready", 64'(stray), 64'd0);
    launch32(1'b1, 32'd5, 32'd5, 64'd25);
    wait32("post_reset", 17, 1'b0);

    // Narrow instance: five steps per product.
    run8(1'b1, 8'hF3, 8'h05, 16'hFFBF, 1'b0, "w8 signed");
    run8(1'b0, 8'hF3, 8'h05, 16'h04BF, 1'b1, "w8 unsigned");
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, "w8 ones");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule

// File: doc/mult_booth_seq.md
MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 Derived constant N = WIDTH/2 + 1 SHALL be the iteration count; the counter SHALL be clog2(N+1) bits wide.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a multiply; sampled on the rising edge of clock.
REQ-006 is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-007 multiplicand  input  WIDTH  operand M.
REQ-008 multiplier  input  WIDTH  operand Q.
REQ-009 result  output  2*WIDTH  full product, registered.
REQ-010 overflow  output  1  product does not fit in WIDTH bits for the selected mode, registered.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 ready  output  1  one-cycle pulse marking result/overflow newly valid.

Function
REQ-013 States SHALL be IDLE, RUN and DONE, encoded in a registered state variable.
REQ-014 IDLE or DONE with start=1 at an edge: latch M, Q and is_signed; clear the accumulator and count; go to RUN.
REQ-015 IDLE with start=0: stay IDLE. DONE with start=0: go to IDLE.
REQ-016 RUN SHALL ignore start and any change on the multiplicand, multiplier and is_signed inputs.
REQ-017 At latch time, M and Q SHALL be extended to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when is_signed=0; the Q[-1] bit SHALL be cleared.
REQ-018 Each RUN edge SHALL perform one radix-4 Booth step on the triplet {Q1,Q0,Q-1}:
  - 000 or 111: no operation;
  - 001 or 010: add M;
  - 011: add 2M;
  - 100: subtract 2M;
  - 101 or 110: subtract M.
  The accumulator, Q and Q-1 SHALL then shift right together by 2 as an arithmetic shift.
REQ-019 The accumulator SHALL be at least WIDTH+3 bits so that the 2M terms never overflow internally.
REQ-020 After the Nth RUN edge, the state SHALL go to DONE. On that same edge, result SHALL load the low 2*WIDTH bits of the product and overflow SHALL load its flag.
REQ-021 overflow rules:
  - is_signed=1: set when result[2*WIDTH-1:WIDTH-1] is not all equal bits;
  - is_signed=0: set when result[2*WIDTH-1:WIDTH] is nonzero.
REQ-022 busy SHALL be 1 exactly in RUN. ready SHALL be 1 exactly in DONE.
REQ-023 Latency: start sampled at edge k gives busy=1 after edges k..k+N-1 and ready=1 for the single cycle after edge k+N.
REQ-024 result and overflow SHALL hold their values until the next DONE entry or a reset.
REQ-025 Back-to-back: start=1 in DONE SHALL begin the next operation with no idle cycle; ready SHALL then fall after one cycle.
REQ-026 Operand values 0, the most negative value, and all-ones SHALL produce exact results with no special-casing.

Reset
REQ-027 resetn=0 SHALL immediately force state=IDLE and set result=0, overflow=0, busy=0, ready=0, and count=0, regardless of the clock.
REQ-028 Reset during RUN SHALL abandon the operation; no ready pulse SHALL follow for it.
REQ-029 The first start SHALL be honoured on the first rising edge at which resetn=1.

Verification
REQ-030 WIDTH=32, signed, M=7, Q=-3 -> ready exactly 17 edges after the start edge; result=64'hFFFFFFFF_FFFFFFEB; overflow=0.
REQ-031 WIDTH=32, M=Q=32'hFFFFFFFF:
  - unsigned -> result=64'hFFFFFFFE_00000001, overflow=1;
  - signed -> result=64'h1, overflow=0.
REQ-032 WIDTH=32, signed, M=Q=32'h80000000 -> result=64'h40000000_00000000, overflow=1.
REQ-033 WIDTH=8, signed, M=8'hF3, Q=8'h05 -> result=16'hFFBF, overflow=0, ready 5 edges after the start edge.
REQ-034 WIDTH=32, start 2*3. Pulse start again with 9*9 while busy -> ignored, result=6. Assert start during DONE with 9*9 -> result=81 with ready 17 edges later.
REQ-035 Drop resetn mid-RUN, clock-asynchronously -> all outputs 0 at once; after release, a new 5*5 signed -> result=25, with no stale ready pulse.
